wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
- Writeback arbitration stage that sits directly upstream of the register file and drives its single write port.
- Two sources share that port:
  - the in-order pipeline writeback, which cannot stall;
  - the multi-cycle mult/div unit, which completes out of step with the pipeline.
- Mult/div results are buffered in a small FIFO and drained into free writeback slots.
- Provides a pending-register mask so decode can stall on outstanding mult/div destinations.

Parameters:
- DEPTH, 2, number of mult/div result FIFO entries (power of two, 2..8).
- DW, 32, data width.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- ctrl_reset  in  1  asynchronous reset, active-high.
- pipe_we  in  1  pipeline writeback valid this cycle.
- pipe_rd  in  5  pipeline destination register.
- pipe_data  in  DW  pipeline writeback data.
- md_valid  in  1  mult/div result offered.
- md_rd  in  5  mult/div destination register.
- md_data  in  DW  mult/div result.
- md_ready  out  1  FIFO can accept; equals not-full.
- ctrl_writeEnable  out  1  register-file write enable (registered).
- ctrl_writeReg  out  5  register-file write index (registered).
- data_writeReg  out  DW  register-file write data (registered).
- pending_mask  out  32  bit i = 1 if a not-yet-committed mult/div write to register i exists.

Behaviour:
- Reset (async, immediate): FIFO emptied (all entries invalid, pointers and count = 0). ctrl_writeEnable = 0, ctrl_writeReg = 0, data_writeReg = 0, pending_mask = 0, md_ready = 1.
- Handshake: md_valid && md_ready at a rising edge is an accept. md_ready depends only on the count (no combinational path from md_valid or pipe_we). When full, no accept occurs, even if a pop happens in the same cycle.
- r0 writes:
  - pipe_we with pipe_rd = 0 is treated as no write.
  - An accepted md result with md_rd = 0 is consumed and discarded; it is never enqueued and never sets a mask bit.
- Priority at each edge: output registers load the first applicable item below.
  - If pipe_we && pipe_rd != 0: load the pipe write.
  - Otherwise, if the FIFO is non-empty: pop the head. If the head is valid, load it with we = 1; if it is killed, load we = 0.
  - Otherwise: load we = 0.
- Latency:
  - Pipe write appears on the outputs 1 cycle after presentation.
  - An md result accepted at edge t is eligible for pop at edge t+1, so the earliest it appears on the outputs is after edge t+1.
- WAW kill: a pipe write to register X (X != 0) kills every valid FIFO entry with rd = X. This applies to entries already queued and to an md result accepted at the same edge for rd = X. Killed entries still occupy their slot until popped, but produce no write.
- pending_mask: OR of one-hot(rd) over valid FIFO entries, plus one-hot(ctrl_writeReg) while ctrl_writeEnable = 1 for an output loaded from the FIFO. It is combinational from state and never includes bit 0.
- Simultaneous push and pop (FIFO not full): both happen; count is unchanged; pointers wrap modulo DEPTH.
- Reset asserted mid-drain: all queued results are lost; no write is issued after reset deasserts until new input arrives.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: when the FIFO is empty and there is no pipe write this cycle, an accepted valid md result (md_rd != 0) loads the output registers directly at the accept edge, giving 1-cycle latency. It is not enqueued in this case.
- Undefined: every md result passes through the FIFO, with a minimum of 2 cycles to the outputs.

Test Plan:
- Reset, then pipe_we = 1, rd = 5, data = 0x1234 for one cycle -> next cycle ctrl_writeEnable = 1, ctrl_writeReg = 5, data_writeReg = 0x1234; following cycle enable = 0.
- md result rd = 7, data = 0xAAAA accepted while pipe idle (bypass undefined) -> pending_mask = 0x80 for two cycles; output write rd = 7 appears 2 cycles after accept; mask then returns to 0.
- Continuous pipe writes for 4 cycles while md offers rd = 3 and rd = 4 (DEPTH = 2) -> both accepted, a third offer sees md_ready = 0; after the pipe goes idle, writes rd = 3 then rd = 4 issue in order.
- md rd = 9 queued behind pipe traffic, then pipe writes rd = 9, data = 0x55 -> entry killed; bit 9 clears; the later pop produces enable = 0; the register file sees only 0x55.
- md_rd = 0 and pipe_rd = 0 offered -> no write ever issued; pending_mask stays 0.
- FIFO holding 2 entries, ctrl_reset pulsed mid-cycle -> outputs and mask drop to 0 immediately, md_ready = 1, no queued write emerges afterwards.

Source files
------------

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - register-file writeback arbiter: pipeline priority, mult/div result FIFO, pending mask
// Optional macro WB_BYPASS_EN lets an md result skip the empty FIFO straight to the write port.
module wb_arbiter #(
   parameter int DEPTH = 2,
   parameter int DW    = 32
) (
   input  logic          clock,
   input  logic          ctrl_reset,
   input  logic          pipe_we,
   input  logic [4:0]    pipe_rd,
   input  logic [DW-1:0] pipe_data,
   input  logic          md_valid,
   input  logic [4:0]    md_rd,
   input  logic [DW-1:0] md_data,
   output logic          md_ready,
   output logic          ctrl_writeEnable,
   output logic [4:0]    ctrl_writeReg,
   output logic [DW-1:0] data_writeReg,
   output logic [31:0]   pending_mask
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

   logic [4:0]       rd_q   [DEPTH];
   logic [DW-1:0]    data_q [DEPTH];
   logic [DEPTH-1:0] live_q;
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             out_from_fifo;

   logic pipe_hit;
   logic accept;
   logic md_live;
   logic bypass;
   logic push;
   logic pop;

   assign md_ready = (count != FULL_CNT);
   assign pipe_hit = pipe_we && (pipe_rd != 5'd0);
   assign accept   = md_valid && md_ready;
   assign md_live  = accept && (md_rd != 5'd0);
`ifdef WB_BYPASS_EN
   assign bypass   = (count == '0) && !pipe_hit && md_live;
`else
   assign bypass   = 1'b0;
`endif
   assign push     = md_live && !bypass;
   assign pop      = !pipe_hit && (count != '0);

   // Killed entries keep their slot, so live_q (not count) drives the mask.
   always_comb begin
      pending_mask = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (live_q[i]) pending_mask[rd_q[i]] = 1'b1;
      end
      if (out_from_fifo && ctrl_writeEnable) pending_mask[ctrl_writeReg] = 1'b1;
      pending_mask[0] = 1'b0;
   end

   always_ff @(posedge clock or posedge ctrl_reset) begin
      if (ctrl_reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            rd_q[i]   <= '0;
            data_q[i] <= '0;
         end
         live_q           <= '0;
         wr_ptr           <= '0;
         rd_ptr           <= '0;
         count            <= '0;
         out_from_fifo    <= 1'b0;
         ctrl_writeEnable <= 1'b0;
         ctrl_writeReg    <= '0;
         data_writeReg    <= '0;
      end else begin
         // A younger pipeline write to the same register makes queued results stale.
         for (int i = 0; i < DEPTH; i++) begin
            if (pipe_hit && rd_q[i] == pipe_rd) live_q[i] <= 1'b0;
         end
         if (pop) begin
            live_q[rd_ptr] <= 1'b0;
            rd_ptr         <= rd_ptr + 1'b1;
         end
         if (push) begin
            rd_q[wr_ptr]   <= md_rd;
            data_q[wr_ptr] <= md_data;
            live_q[wr_ptr] <= !(pipe_hit && md_rd == pipe_rd);
            wr_ptr         <= wr_ptr + 1'b1;
         end
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;

         if (pipe_hit) begin
            ctrl_writeEnable <= 1'b1;
            ctrl_writeReg    <= pipe_rd;
            data_writeReg    <= pipe_data;
            out_from_fifo    <= 1'b0;
         end else if (pop) begin
            ctrl_writeEnable <= live_q[rd_ptr];
            ctrl_writeReg    <= rd_q[rd_ptr];
            data_writeReg    <= data_q[rd_ptr];
            out_from_fifo    <= 1'b1;
         end else if (bypass) begin
            ctrl_writeEnable <= 1'b1;
            ctrl_writeReg    <= md_rd;
            data_writeReg    <= md_data;
            out_from_fifo    <= 1'b0;
         end else begin
            ctrl_writeEnable <= 1'b0;
            out_from_fifo    <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - directed bench for wb_arbiter (default build, DEPTH = 2)
module tb_wb_arbiter;

   logic        clock = 1'b0;
   logic        ctrl_reset;
   logic        pipe_we;
   logic [4:0]  pipe_rd;
   logic [31:0] pipe_data;
   logic        md_valid;
   logic [4:0]  md_rd;
   logic [31:0] md_data;
   logic        md_ready;
   logic        ctrl_writeEnable;
   logic [4:0]  ctrl_writeReg;
   logic [31:0] data_writeReg;
   logic [31:0] pending_mask;

   int nvec = 0;
   int nfail = 0;

   wb_arbiter #(.DEPTH(2), .DW(32)) dut (
      .clock(clock), .ctrl_reset(ctrl_reset),
      .pipe_we(pipe_we), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
      .md_valid(md_valid), .md_rd(md_rd), .md_data(md_data), .md_ready(md_ready),
      .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
      .data_writeReg(data_writeReg), .pending_mask(pending_mask)
   );

   always #5 clock = ~clock;

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs;
      pipe_we = 1'b0; pipe_rd = '0; pipe_data = '0;
      md_valid = 1'b0; md_rd = '0; md_data = '0;
   endtask

   task automatic do_reset;
      ctrl_reset = 1'b1;
      idle_inputs();
      tick();
      tick();
      ctrl_reset = 1'b0;
   endtask

   task automatic test_reset;
      do_reset();
      nvec++; if (ctrl_writeEnable !== 1'b0) begin nfail++; $display("FAIL reset_we: got %0b want 0", ctrl_writeEnable); end
      nvec++; if (ctrl_writeReg !== 5'd0) begin nfail++; $display("FAIL reset_reg: got %0d want 0", ctrl_writeReg); end
      nvec++; if (data_writeReg !== 32'd0) begin nfail++; $display("FAIL reset_data: got %h want 0", data_writeReg); end
      nvec++; if (pending_mask !== 32'd0) begin nfail++; $display("FAIL reset_mask: got %h want 0", pending_mask); end
      nvec++; if (md_ready !== 1'b1) begin nfail++; $display("FAIL reset_ready: got %0b want 1", md_ready); end
   endtask

   task automatic test_pipe_write;
      pipe_we = 1'b1; pipe_rd = 5'd5; pipe_data = 32'h1234;
      tick();
      idle_inputs();
      nvec++; if (ctrl_writeEnable !== 1'b1) begin nfail++; $display("FAIL pipe_we: got %0b want 1", ctrl_writeEnable); end
      nvec++; if (ctrl_writeReg !== 5'd5) begin nfail++; $display("FAIL pipe_reg: got %0d want 5", ctrl_writeReg); end
      nvec++; if (data_writeReg !== 32'h1234) begin nfail++; $display("FAIL pipe_data: got %h want 1234", data_writeReg); end
      tick();
      nvec++; if (ctrl_writeEnable !== 1'b0) begin nfail++; $display("FAIL pipe_we_drop: got %0b want 0", ctrl_writeEnable); end
   endtask

   task automatic test_md_latency;
      md_valid = 1'b1; md_rd = 5'd7; md_data = 32'hAAAA;
      nvec++; if (md_ready !== 1'b1) begin nfail++; $display("FAIL md_ready_empty: got %0b want 1", md_ready); end
      tick();
      idle_inputs();
      nvec++; if (pending_mask !== 32'h80) begin nfail++; $display("FAIL md_mask_q: got %h want 80", pending_mask); end
      nvec++; if (ctrl_writeEnable !== 1'b0) begin nfail++; $display("FAIL md_we_early: got %0b want 0", ctrl_writeEnable); end
      tick();
      nvec++; if (ctrl_writeEnable !== 1'b1) begin nfail++; $display("FAIL md_we: got %0b want 1", ctrl_writeEnable); end
      nvec++; if (ctrl_writeReg !== 5'd7) begin nfail++; $display("FAIL md_reg: got %0d want 7", ctrl_writeReg); end
      nvec++; if (data_writeReg !== 32'hAAAA) begin nfail++; $display("FAIL md_data: got %h want aaaa", data_writeReg); end
      nvec++; if (pending_mask !== 32'h80) begin nfail++; $display("FAIL md_mask_out: got %h want 80", pending_mask); end
      tick();
      nvec++; if (ctrl_writeEnable !== 1'b0) begin nfail++; $display("FAIL md_we_drop: got %0b want 0", ctrl_writeEnable); end
      nvec++; if (pending_mask !== 32'h0) begin nfail++; $display("FAIL md_mask_clear: got %h want 0", pending_mask); end
   endtask

   task automatic test_back_to_back;
      pipe_we = 1'b1; pipe_rd = 5'd10; pipe_data = 32'hA0;
      md_valid = 1'b1; md_rd = 5'd3; md_data = 32'h33;
      tick();
      nvec++; if (ctrl_writeReg !== 5'd10 || ctrl_writeEnable !== 1'b1) begin nfail++; $display("FAIL b2b_pipe1: got we=%0b rd=%0d want we=1 rd=10", ctrl_writeEnable, ctrl_writeReg); end
      nvec++; if (pending_mask !== 32'h08) begin nfail++; $display("FAIL b2b_mask1: got %h want 8", pending_mask); end
      pipe_rd = 5'd11; pipe_data = 32'hA1; md_rd = 5'd4; md_data = 32'h44;
      tick();
      nvec++; if (pending_mask !== 32'h18) begin nfail++; $display("FAIL b2b_mask2: got %h want 18", pending_mask); end
      pipe_rd = 5'd12; pipe_data = 32'hA2; md_rd = 5'd5; md_data = 32'h55;
      nvec++; if (md_ready !== 1'b0) begin nfail++; $display("FAIL b2b_full: got %0b want 0", md_ready); end
      tick();
      nvec++; if (pending_mask !== 32'h18) begin nfail++; $display("FAIL b2b_no_accept: got %h want 18", pending_mask); end
      md_valid = 1'b0; pipe_rd = 5'd13; pipe_data = 32'hA3;
      tick();
      nvec++; if (ctrl_writeReg !== 5'd13 || data_writeReg !== 32'hA3) begin nfail++; $display("FAIL b2b_pipe4: got rd=%0d data=%h want rd=13 data=a3", ctrl_writeReg, data_writeReg); end
      idle_inputs();
      tick();
      nvec++; if (ctrl_writeEnable !== 1'b1 || ctrl_writeReg !== 5'd3 || data_writeReg !== 32'h33) begin nfail++; $display("FAIL b2b_drain3: got we=%0b rd=%0d data=%h want we=1 rd=3 data=33", ctrl_writeEnable, ctrl_writeReg, data_writeReg); end
      nvec++; if (pending_mask !== 32'h18) begin nfail++; $display("FAIL b2b_mask_d3: got %h want 18", pending_mask); end
      tick();
      nvec++; if (ctrl_writeEnable !== 1'b1 || ctrl_writeReg !== 5'd4 || data_writeReg !== 32'h44) begin nfail++; $display("FAIL b2b_drain4: got we=%0b rd=%0d data=%h want we=1 rd=4 data=44", ctrl_writeEnable, ctrl_writeReg, data_writeReg); end
      nvec++; if (pending_mask !== 32'h10) begin nfail++; $display("FAIL b2b_mask_d4: got %h want 10", pending_mask); end
      tick();
      nvec++; if (ctrl_writeEnable !== 1'b0 || pending_mask !== 32'h0) begin nfail++; $display("FAIL b2b_done: got we=%0b mask=%h want we=0 mask=0", ctrl_writeEnable, pending_mask); end
   endtask

   task automatic test_waw_kill;
      pipe_we = 1'b1; pipe_rd = 5'd20; pipe_data = 32'h20;
      md_valid = 1'b1; md_rd = 5'd9; md_data = 32'h99;
      tick();
      nvec++; if (pending_mask !== 32'h200) begin nfail++; $display("FAIL kill_mask_q: got %h want 200", pending_mask); end
      md_valid = 1'b0; pipe_rd = 5'd9; pipe_data = 32'h55;
      tick();
      nvec++; if (ctrl_writeEnable !== 1'b1 || ctrl_writeReg !== 5'd9 || data_writeReg !== 32'h55) begin nfail++; $display("FAIL kill_pipe: got we=%0b rd=%0d data=%h want we=1 rd=9 data=55", ctrl_writeEnable, ctrl_writeReg, data_writeReg); end
      nvec++; if (pending_mask !== 32'h0) begin nfail++; $display("FAIL kill_mask: got %h want 0", pending_mask); end
      idle_inputs();
      tick();
      nvec++; if (ctrl_writeEnable !== 1'b0) begin nfail++; $display("FAIL kill_pop: got %0b want 0", ctrl_writeEnable); end
      nvec++; if (pending_mask !== 32'h0) begin nfail++; $display("FAIL kill_pop_mask: got %h want 0", pending_mask); end
      tick();
      nvec++; if (ctrl_writeEnable !== 1'b0) begin nfail++; $display("FAIL kill_after: got %0b want 0", ctrl_writeEnable); end
   endtask

   task automatic test_r0;
      pipe_we = 1'b1; pipe_rd = 5'd0; pipe_data = 32'hDEAD;
      md_valid = 1'b1; md_rd = 5'd0; md_data = 32'hBEEF;
      tick();
      idle_inputs();
      nvec++; if (ctrl_writeEnable !== 1'b0) begin nfail++; $display("FAIL r0_we: got %0b want 0", ctrl_writeEnable); end
      nvec++; if (pending_mask !== 32'h0) begin nfail++; $display("FAIL r0_mask: got %h want 0", pending_mask); end
      nvec++; if (md_ready !== 1'b1) begin nfail++; $display("FAIL r0_ready: got %0b want 1", md_ready); end
      for (int i = 0; i < 3; i++) begin
         tick();
         nvec++; if (ctrl_writeEnable !== 1'b0) begin nfail++; $display("FAIL r0_idle%0d: got %0b want 0", i, ctrl_writeEnable); end
      end
   endtask

   task automatic test_reset_mid;
      pipe_we = 1'b1; pipe_rd = 5'd20; pipe_data = 32'h1;
      md_valid = 1'b1; md_rd = 5'd3; md_data = 32'h3;
      tick();
      md_rd = 5'd4; md_data = 32'h4;
      tick();
      idle_inputs();
      nvec++; if (pending_mask !== 32'h18 || md_ready !== 1'b0) begin nfail++; $display("FAIL rstmid_full: got mask=%h ready=%0b want mask=18 ready=0", pending_mask, md_ready); end
      #2;
      ctrl_reset = 1'b1;
      #1;
      nvec++; if (ctrl_writeEnable !== 1'b0 || ctrl_writeReg !== 5'd0 || data_writeReg !== 32'd0) begin nfail++; $display("FAIL rstmid_out: got we=%0b rd=%0d data=%h want all 0", ctrl_writeEnable, ctrl_writeReg, data_writeReg); end
      nvec++; if (pending_mask !== 32'h0) begin nfail++; $display("FAIL rstmid_mask: got %h want 0", pending_mask); end
      nvec++; if (md_ready !== 1'b1) begin nfail++; $display("FAIL rstmid_ready: got %0b want 1", md_ready); end
      tick();
      ctrl_reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         nvec++; if (ctrl_writeEnable !== 1'b0 || pending_mask !== 32'h0) begin nfail++; $display("FAIL rstmid_after%0d: got we=%0b mask=%h want 0", i, ctrl_writeEnable, pending_mask); end
      end
   endtask

   initial begin
      test_reset();
      test_pipe_write();
      test_md_latency();
      test_back_to_back();
      test_waw_kill();
      test_r0();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
